// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the requesters and the 3-input mux arbiter.
// master drives requests and done; slave (the arbiter) drives grant, sel and busy.
interface mux_rr_arbiter_if;
  logic [2:0] req;
  logic       done;
  logic [2:0] grant;
  logic [2:0] sel;
  logic       busy;

  modport master (
    output req,
    output done,
    input  grant,
    input  sel,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output sel,
    output busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared 3-input mux, with a hold limit and a GAP cycle between owners.
// Grant appears one edge after a request; no backpressure, all outputs registered.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam logic [2:0] SEL_NONE = 3'b100;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_grant, w_grant_nxt;
  logic [2:0] r_sel,   w_sel_nxt;
  logic       r_busy,  w_busy_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;
  logic [1:0] r_last,  w_last_nxt;

  logic [1:0] w_start;
  logic [1:0] w_win;
  logic       w_found;
  logic [2:0] w_pos;
  logic       w_exit;

  // Scan upward from the slot after the last owner, wrapping 2 -> 0.
  always_comb begin
    w_start = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    w_win   = 2'd0;
    w_found = 1'b0;
    w_pos   = 3'd0;
    for (int k = 0; k < 3; k++) begin
      w_pos = {1'b0, w_start} + 3'(k);
      if (w_pos >= 3'd3) begin
        w_pos = w_pos - 3'd3;
      end
      if (!w_found && bus.req[w_pos[1:0]]) begin
        w_found = 1'b1;
        w_win   = w_pos[1:0];
      end
    end
  end

  // r_last always holds the current owner while in GRANT.
  assign w_exit = bus.done || !bus.req[r_last] || (r_cnt == HOLD_LIM);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = 3'b000;
    w_sel_nxt   = SEL_NONE;
    w_busy_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = 3'b001 << w_win;
          w_sel_nxt   = {1'b0, w_win};
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = 8'd1;
          w_last_nxt  = w_win;
        end
      end
      ST_GRANT: begin
        if (w_exit) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_grant_nxt = r_grant;
          w_sel_nxt   = r_sel;
          w_busy_nxt  = 1'b1;
          if (r_cnt != 8'hFF) begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= 3'b000;
      r_sel   <= SEL_NONE;
      r_busy  <= 1'b0;
      r_cnt   <= 8'd0;
      r_last  <= 2'd2;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign bus.grant = r_grant;
  assign bus.sel   = r_sel;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: three instances (hold limits 8, 4, 1) share one stimulus stream
// and are compared every cycle against an ownership-level reference model.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic       done;

  logic [2:0] obs_grant [3];
  logic [2:0] obs_sel   [3];
  logic       obs_busy  [3];

  int n_checks;
  int n_errors;

  // Reference model: who owns the mux, for how long, and how many blank cycles remain.
  int hold_of [3] = '{8, 4, 1};
  int m_owner [3];
  int m_held  [3];
  int m_gap   [3];
  int m_last  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned HOLD = (g == 0) ? 8 : (g == 1) ? 4 : 1;
    mux_rr_arbiter_if bus ();
    assign bus.req      = req;
    assign bus.done     = done;
    assign obs_grant[g] = bus.grant;
    assign obs_sel[g]   = bus.sel;
    assign obs_busy[g]  = bus.busy;
    mux_rr_arbiter #(.MAX_HOLD(HOLD)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_owner[i] = -1;
    m_held[i]  = 0;
    m_gap[i]   = 0;
    m_last[i]  = 2;
  endtask

  task automatic model_step(input int i);
    int c;
    if (!rst_n) begin
      model_reset(i);
    end else if (m_owner[i] >= 0) begin
      if (done || !req[m_owner[i]] || m_held[i] == hold_of[i]) begin
        m_owner[i] = -1;
        m_gap[i]   = 1;
      end else if (m_held[i] < 255) begin
        m_held[i]++;
      end
    end else if (m_gap[i] > 0) begin
      m_gap[i]--;
    end else if (req != 3'b000) begin
      for (int k = 0; k < 3; k++) begin
        c = (m_last[i] + 1 + k) % 3;
        if (m_owner[i] < 0 && req[c]) begin
          m_owner[i] = c;
        end
      end
      m_last[i] = m_owner[i];
      m_held[i] = 1;
    end
  endtask

  task automatic check_all();
    logic [2:0] eg, es;
    logic       eb;
    for (int i = 0; i < 3; i++) begin
      eg = (m_owner[i] < 0) ? 3'b000 : 3'(1 << m_owner[i]);
      es = (m_owner[i] < 0) ? 3'b100 : 3'(m_owner[i]);
      eb = (m_owner[i] >= 0);
      chk($sformatf("model.grant[%0d]", i), 32'(obs_grant[i]), 32'(eg));
      chk($sformatf("model.sel[%0d]", i), 32'(obs_sel[i]), 32'(es));
      chk($sformatf("model.busy[%0d]", i), 32'(obs_busy[i]), 32'(eb));
    end
  endtask

  task automatic expect_out(input string tag, input int i, input logic [2:0] g,
                            input logic [2:0] s, input logic b);
    chk($sformatf("%s.grant[%0d]", tag, i), 32'(obs_grant[i]), 32'(g));
    chk($sformatf("%s.sel[%0d]", tag, i), 32'(obs_sel[i]), 32'(s));
    chk($sformatf("%s.busy[%0d]", tag, i), 32'(obs_busy[i]), 32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    check_all();
  endtask

  // Called 1 time unit after an edge: pulls reset low between edges and releases it at the negedge.
  task automatic async_reset(input logic [2:0] req_after);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) model_reset(i);
    for (int i = 0; i < 3; i++) expect_out("async_rst", i, 3'b000, 3'b100, 1'b0);
    check_all();
    req = req_after;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    req      = 3'b000;
    done     = 1'b0;
    for (int i = 0; i < 3; i++) model_reset(i);
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset then idle
    for (int t = 0; t < 10; t++) begin
      tick();
      expect_out("idle", 0, 3'b000, 3'b100, 1'b0);
    end

    // Single request with early release by done
    req = 3'b010;
    repeat (3) begin
      tick();
      expect_out("single", 0, 3'b010, 3'b001, 1'b1);
    end
    done = 1'b1;
    tick();
    expect_out("single_gap", 0, 3'b000, 3'b100, 1'b0);
    done = 1'b0;
    tick();
    expect_out("single_idle", 0, 3'b000, 3'b100, 1'b0);
    req = 3'b000;
    tick();

    // Round robin with done held high through every grant
    async_reset(3'b111);
    done = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if ((t - 1) % 3 == 0) begin
        expect_out("rr", 0, 3'(1 << (((t - 1) / 3) % 3)), 3'(((t - 1) / 3) % 3), 1'b1);
      end else begin
        expect_out("rr_gap", 0, 3'b000, 3'b100, 1'b0);
      end
    end
    done = 1'b0;

    // Timeout on the MAX_HOLD=4 instance
    async_reset(3'b001);
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t <= 4 || t == 7) expect_out("timeout", 1, 3'b001, 3'b000, 1'b1);
      else                  expect_out("timeout_gap", 1, 3'b000, 3'b100, 1'b0);
    end

    // Owner drop, done and hold limit all on one edge
    async_reset(3'b110);
    repeat (4) begin
      tick();
      expect_out("coinc", 1, 3'b010, 3'b001, 1'b1);
    end
    req  = 3'b100;
    done = 1'b1;
    tick();
    expect_out("coinc_gap", 1, 3'b000, 3'b100, 1'b0);
    done = 1'b0;
    tick();
    expect_out("coinc_idle", 1, 3'b000, 3'b100, 1'b0);
    tick();
    expect_out("coinc_next", 1, 3'b100, 3'b010, 1'b1);

    // Reset mid-grant, then first grant after release
    async_reset(3'b111);
    repeat (2) tick();
    expect_out("pre_rst", 0, 3'b001, 3'b000, 1'b1);
    async_reset(3'b110);
    tick();
    expect_out("post_rst", 0, 3'b010, 3'b001, 1'b1);

    // Randomized traffic with occasional mid-cycle resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 249) == 0) async_reset(req);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
